// File: rtl/rsu_pkg.sv
//------------------------------------------------------------------------------
// Module   : rsu_pkg
// Brief    : Shared opcodes and FSM state type for the return-stack unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rsu_pkg;

  localparam logic [5:0] OP_CALL = 6'b000101;
  localparam logic [5:0] OP_RET  = 6'b000100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP_RD  = 2'd1,
    PRESENT = 2'd2
  } rsu_state_t;

endpackage

`default_nettype wire

// File: rtl/rsu_lifo_mem.sv
//------------------------------------------------------------------------------
// Module   : rsu_lifo_mem
// Brief    : DEPTH x AW single-port synchronous RAM, write enable, registered read.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rsu_lifo_mem #(
  parameter int DEPTH  = 16,
  parameter int AW     = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [AW-1:0]     wdata,
  output logic [AW-1:0]     rdata
);

  logic [AW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rdata;

  // No reset on the array or read register so the storage maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/return_stack_unit.sv
//------------------------------------------------------------------------------
// Module   : return_stack_unit
// Brief    : Hardware return-address stack; CALL pushes pc+1, RET pops to PC mux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module return_stack_unit #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 16,
  parameter int         PTR_W   = $clog2(DEPTH) + 1,
  parameter logic [5:0] OP_CALL = rsu_pkg::OP_CALL,
  parameter logic [5:0] OP_RET  = rsu_pkg::OP_RET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [5:0]       opcode,
  input  logic [AW-1:0]    pc,
  input  logic             ret_ready,
  input  logic             clear_err,
  output logic [AW-1:0]    ret_addr,
  output logic             ret_valid,
  output logic             busy,
  output logic [PTR_W-1:0] sp_out,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  import rsu_pkg::*;

  localparam int c_addr_w = $clog2(DEPTH);

  rsu_state_t          r_state;
  rsu_state_t          w_state_next;
  logic [PTR_W-1:0]    r_sp;
  logic [AW-1:0]       r_ret_addr;
  logic                r_ret_valid;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_push;
  logic                w_pop;
  logic                w_ovf_set;
  logic                w_unf_set;
  logic                w_ret_load;
  logic                w_ret_done;
  logic                w_full;
  logic                w_empty;
  logic [c_addr_w-1:0] w_rd_addr;
  logic [c_addr_w-1:0] w_mem_addr;
  logic [AW-1:0]       w_mem_rdata;
  logic [AW-1:0]       w_push_data;

  assign w_full      = (r_sp == PTR_W'(DEPTH));
  assign w_empty     = (r_sp == '0);
  assign w_push_data = pc + AW'(1);

  // The RAM read is launched in the command cycle at sp-1, so its output is
  // ready during POP_RD and captured into ret_addr on the following edge.
  assign w_rd_addr  = r_sp[c_addr_w-1:0] - c_addr_w'(1);
  assign w_mem_addr = w_push ? r_sp[c_addr_w-1:0] : w_rd_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    w_ret_load   = 1'b0;
    w_ret_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && (opcode == OP_CALL)) begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end else if (enable && (opcode == OP_RET)) begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_pop        = 1'b1;
            w_state_next = POP_RD;
          end
        end
      end
      POP_RD: begin
        w_ret_load   = 1'b1;
        w_state_next = PRESENT;
      end
      PRESENT: begin
        if (ret_ready) begin
          w_ret_done   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp        <= '0;
      r_ret_addr  <= '0;
      r_ret_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_sp <= r_sp + PTR_W'(1);
      end else if (w_pop) begin
        r_sp <= r_sp - PTR_W'(1);
      end
      if (w_ret_load) begin
        r_ret_addr  <= w_mem_rdata;
        r_ret_valid <= 1'b1;
      end else if (w_ret_done) begin
        r_ret_valid <= 1'b0;
      end
      // A new error in the same cycle as clear_err takes priority.
      r_overflow  <= w_ovf_set | (r_overflow  & ~clear_err);
      r_underflow <= w_unf_set | (r_underflow & ~clear_err);
    end
  end

  rsu_lifo_mem #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .ADDR_W (c_addr_w)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .re    (w_pop),
    .addr  (w_mem_addr),
    .wdata (w_push_data),
    .rdata (w_mem_rdata)
  );

  assign ret_addr  = r_ret_addr;
  assign ret_valid = r_ret_valid;
  assign busy      = (r_state != IDLE);
  assign sp_out    = r_sp;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_return_stack_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_return_stack_unit
// Brief    : Directed self-checking bench for return_stack_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_return_stack_unit;

  localparam int         DEPTH   = 16;
  localparam int         AW      = 16;
  localparam int         PTR_W   = 5;
  localparam logic [5:0] C_CALL  = 6'b000101;
  localparam logic [5:0] C_RET   = 6'b000100;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [5:0]       opcode;
  logic [AW-1:0]    pc;
  logic             ret_ready;
  logic             clear_err;
  logic [AW-1:0]    ret_addr;
  logic             ret_valid;
  logic             busy;
  logic [PTR_W-1:0] sp_out;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_fail   = 0;

  return_stack_unit #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .opcode    (opcode),
    .pc        (pc),
    .ret_ready (ret_ready),
    .clear_err (clear_err),
    .ret_addr  (ret_addr),
    .ret_valid (ret_valid),
    .busy      (busy),
    .sp_out    (sp_out),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic push(input logic [AW-1:0] v);
    enable = 1'b1;
    opcode = C_CALL;
    pc     = v;
    tick();
    enable = 1'b0;
    opcode = 6'd0;
  endtask

  // Pop with ret_ready held high: valid after two edges, handshake on the third.
  task automatic pop_expect(input string tag, input logic [AW-1:0] exp);
    ret_ready = 1'b1;
    enable    = 1'b1;
    opcode    = C_RET;
    tick();
    enable = 1'b0;
    opcode = 6'd0;
    check({tag, "_valid_n1"}, 32'(ret_valid), 32'd0);
    tick();
    check({tag, "_valid_n2"}, 32'(ret_valid), 32'd1);
    check({tag, "_addr"}, 32'(ret_addr), 32'(exp));
    tick();
    check({tag, "_valid_done"}, 32'(ret_valid), 32'd0);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    opcode    = 6'd0;
    pc        = '0;
    ret_ready = 1'b0;
    clear_err = 1'b0;
    #12;
    check("reset_sp", 32'(sp_out), 32'd0);
    check("reset_valid", 32'(ret_valid), 32'd0);
    check("reset_addr", 32'(ret_addr), 32'd0);
    reset = 1'b0;
    tick();
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_unf", 32'(underflow), 32'd0);

    // Push then pop
    push(16'hA42F);
    check("p1_sp", 32'(sp_out), 32'd1);
    pop_expect("p1_pop", 16'hA430);
    check("p1_sp_after", 32'(sp_out), 32'd0);
    check("p1_empty", 32'(empty), 32'd1);

    // LIFO order
    push(16'h9BC2);
    push(16'h7D10);
    push(16'h22E4);
    check("lifo_sp", 32'(sp_out), 32'd3);
    pop_expect("lifo_a", 16'h22E5);
    pop_expect("lifo_b", 16'h7D11);
    pop_expect("lifo_c", 16'h9BC3);

    // Backpressure with an ignored push while busy
    push(16'h1111);
    ret_ready = 1'b0;
    enable    = 1'b1;
    opcode    = C_RET;
    tick();
    opcode = C_CALL;
    pc     = 16'h5555;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(ret_valid), 32'd1);
      check("bp_addr", 32'(ret_addr), 32'h1112);
      check("bp_sp", 32'(sp_out), 32'd0);
      tick();
    end
    enable = 1'b0;
    opcode = 6'd0;
    check("bp_busy_held", 32'(busy), 32'd1);
    ret_ready = 1'b1;
    tick();
    check("bp_valid_done", 32'(ret_valid), 32'd0);
    check("bp_busy_done", 32'(busy), 32'd0);
    check("bp_addr_kept", 32'(ret_addr), 32'h1112);
    check("bp_sp_final", 32'(sp_out), 32'd0);

    // Full / overflow
    for (int i = 0; i < DEPTH; i++) begin
      push(16'h0100 + 16'(i));
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_sp", 32'(sp_out), 32'd16);
    check("full_ovf_pre", 32'(overflow), 32'd0);
    push(16'h1234);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_sp", 32'(sp_out), 32'd16);
    clear_err = 1'b1;
    tick();
    check("ovf_clear", 32'(overflow), 32'd0);
    push(16'h1234);
    clear_err = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    pop_expect("full_top", 16'h0110);
    check("full_sp_after", 32'(sp_out), 32'd15);
    check("full_flag_after", 32'(full), 32'd0);

    // Empty / underflow and PC wrap
    do_reset();
    check("unf_reset_ovf", 32'(overflow), 32'd0);
    ret_ready = 1'b1;
    enable    = 1'b1;
    opcode    = C_RET;
    tick();
    enable = 1'b0;
    opcode = 6'd0;
    check("unf_set", 32'(underflow), 32'd1);
    check("unf_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("unf_no_valid", 32'(ret_valid), 32'd0);
      tick();
    end
    push(16'hFFFF);
    pop_expect("wrap", 16'h0000);
    check("unf_sticky", 32'(underflow), 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("unf_clear", 32'(underflow), 32'd0);

    // Asynchronous reset while presenting
    push(16'h4320);
    push(16'h4321);
    ret_ready = 1'b0;
    enable    = 1'b1;
    opcode    = C_RET;
    tick();
    enable = 1'b0;
    opcode = 6'd0;
    tick();
    check("rst_pre_valid", 32'(ret_valid), 32'd1);
    check("rst_pre_sp", 32'(sp_out), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_valid", 32'(ret_valid), 32'd0);
    check("rst_async_sp", 32'(sp_out), 32'd0);
    check("rst_async_empty", 32'(empty), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("rst_post_valid", 32'(ret_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/return_stack_unit.md
Name: return_stack_unit

Overview:
- Hardware return-address stack on the call/return path: the reading end of the stack-pointer store.
- On a CALL-class opcode, pushes the return address (pc + 1) into an internal LIFO.
- On a RET-class opcode, pops the top entry and hands it to the PC-select logic over a valid/ready handshake.
- Sits between the control unit (opcode, enable) and the PC multiplexer; also exports pointer, full/empty and error status.

Parameters:
- DEPTH, 16, number of stack entries; power of two, from 2 to 256.
- AW, 16, address/PC width in bits.
- PTR_W, $clog2(DEPTH)+1, pointer width; holds values 0..DEPTH.
- OP_CALL, 6'b000101, opcode that pushes.
- OP_RET, 6'b000100, opcode that pops.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  command strobe; opcode is sampled only when high.
- opcode  in  6  instruction opcode; compared for exact equality with OP_CALL/OP_RET.
- pc  in  AW  current program counter.
- ret_ready  in  1  PC mux accepts ret_addr.
- clear_err  in  1  synchronous clear of the sticky error flags.
- ret_addr  out  AW  popped return address.
- ret_valid  out  1  ret_addr is valid.
- busy  out  1  high in any state other than IDLE.
- sp_out  out  PTR_W  current entry count (stack pointer).
- full  out  1  sp_out == DEPTH.
- empty  out  1  sp_out == 0.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (asynchronous, effective immediately):
  - sp = 0, state = IDLE, ret_addr = 0, ret_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
- A command is accepted only when enable=1 and state=IDLE. Commands issued while busy=1 are ignored: no state change, no flag change.
- Any opcode other than OP_CALL/OP_RET is a no-op.
- FSM states: IDLE, POP_RD, PRESENT.
- Push (IDLE, OP_CALL):
  - If not full: at the sampling edge, mem[sp] <= pc + 1, truncated to AW (16'hFFFF wraps to 16'h0000), and sp <= sp + 1. State stays IDLE; sp_out updates one cycle after the command.
  - If full: no write, sp unchanged, overflow <= 1.
- Pop (IDLE, OP_RET):
  - If not empty: edge N: sp <= sp - 1, state <= POP_RD. Edge N+1: ret_addr <= mem[sp], state <= PRESENT, ret_valid <= 1.
  - If empty: sp unchanged, underflow <= 1, state stays IDLE, ret_valid stays 0.
- Latency: ret_valid is asserted 2 cycles after the pop command cycle.
- PRESENT:
  - ret_valid and ret_addr are held stable until ret_valid && ret_ready at a rising edge.
  - At that edge: ret_valid <= 0, state <= IDLE. A new command is accepted from the next cycle.
  - ret_addr keeps its last value after the handshake.
- Memory is synchronous-read with a one-cycle read (POP_RD); it must map to inferred RAM.
- clear_err=1 clears overflow and underflow at the edge. If a new error occurs in the same cycle, the set wins.
- full, empty and busy are combinational decodes of the registered sp and state.
- Reset asserted mid-pop (POP_RD or PRESENT): the FSM returns to IDLE with ret_valid=0, and the popped entry is discarded.
- Push and pop can never occur in the same cycle, because opcode is a single value.

Decomposition:
- Shared package rsu_pkg holds:
  - OP_CALL and OP_RET localparams, shared with the control unit and the stack-pointer logic.
  - The state enum (IDLE, POP_RD, PRESENT).
- One sub-module: rsu_lifo_mem, a DEPTH x AW single-port synchronous RAM with write enable and registered read.
- The FSM, pointer and flags live in the top module.

Test Plan:
- Push then pop:
  - Stimulus: reset; enable=1, opcode=000101, pc=16'hA42F for one cycle; then opcode=000100; ret_ready=1.
  - Required: sp_out=1 after the push; ret_valid=1 two cycles after the pop command with ret_addr=16'hA430; sp_out=0; empty=1.
- LIFO order:
  - Stimulus: push pc=16'h9BC2, 16'h7D10, 16'h22E4; then three pops with ret_ready=1.
  - Required: ret_addr returns 16'h22E5, 16'h7D11, 16'h9BC3 in that order.
- Backpressure:
  - Stimulus: pop with ret_ready=0 held for 5 cycles; issue OP_CALL while busy; then ret_ready=1.
  - Required: ret_valid and ret_addr stay stable for the 5 cycles; the ignored push leaves sp_out unchanged; handshake completes, then busy=0.
- Full/overflow:
  - Stimulus: 16 pushes, then a 17th push with pc=16'h1234.
  - Required: full=1, sp_out=16, overflow=1; the top pop returns the 16th address, not 16'h1235; clear_err drops overflow.
- Empty/underflow and wrap:
  - Stimulus: pop after reset; then push pc=16'hFFFF and pop.
  - Required: underflow=1 with ret_valid never asserted; the second pop returns ret_addr=16'h0000.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while in PRESENT.
  - Required: ret_valid=0, sp_out=0, empty=1 immediately, without waiting for a clock edge.
